// File: rtl/io_port_responder.sv
// Memory-mapped I/O port: registered output, synchronized input,
// and an input-change FIFO with sticky overflow, in a 16-byte window.
module io_port_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0040,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_P  = AW'(FIFO_DEPTH - 1);

  logic [7:0]    sync1;
  logic [7:0]    sync2;
  logic [7:0]    prev;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;

  logic          sel_out;
  logic          sel_in;
  logic          sel_fifo;
  logic          sel_stat;
  logic          empty;
  logic          full;
  logic          push_req;
  logic          pop_req;
  logic          push_ok;
  logic          pop_ok;
  logic          ovf_set;
  logic          ovf_clr;
  logic          out_we;
  logic [2:0]    cnt3;
  logic [7:0]    head;
  logic          unused_addr;

  function automatic logic [AW-1:0] ptr_inc(
    input logic [AW-1:0] p
  );
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  assign Hit      = (Address[31:4] == BASE_ADDR[31:4]);
  assign sel_out  = (Address[3:2] == 2'd0);
  assign sel_in   = (Address[3:2] == 2'd1);
  assign sel_fifo = (Address[3:2] == 2'd2);
  assign sel_stat = (Address[3:2] == 2'd3);
  assign unused_addr = ^Address[1:0];

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign cnt3  = 3'(count);
  assign head  = empty ? 8'h00 : mem[rd_ptr];

  // A pop only frees a slot if there is something to pop, so
  // push-on-full succeeds only alongside a real pop.
  assign push_req = (sync2 != prev);
  assign pop_req  = MemRead & Hit & sel_fifo;
  assign pop_ok   = pop_req & ~empty;
  assign push_ok  = push_req & (~full | pop_ok);
  assign ovf_set  = push_req & full & ~pop_ok;
  assign ovf_clr  = MemWrite & Hit & sel_stat & WriteData[2];
  assign out_we   = MemWrite & Hit & sel_out;

  always_ff @(posedge clk) begin
    if (!reset) begin
      PortOut <= '0;
      sync1   <= '0;
      sync2   <= '0;
      prev    <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else begin
      sync1 <= PortIn;
      sync2 <= sync1;
      prev  <= sync2;
      if (out_we) begin
        PortOut <= WriteData;
      end
      if (push_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      mem[wr_ptr] <= sync2;
    end
  end

  always_comb begin
    ReadData = '0;
    if (Hit && MemRead) begin
      unique case (1'b1)
        sel_out:  ReadData = PortOut;
        sel_in:   ReadData = {24'b0, sync2};
        sel_fifo: ReadData = {24'b0, head};
        sel_stat: ReadData = {26'b0, cnt3, ovf, full, empty};
        default:  ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Directed and random checks of io_port_responder against a
// queue-based reference model.
module tb_io_port_responder;

  localparam logic [31:0] BASE  = 32'h1001_0040;
  localparam int          DEPTH = 4;
  localparam logic [31:0] A_OUT  = BASE;
  localparam logic [31:0] A_IN   = BASE + 32'h4;
  localparam logic [31:0] A_FIFO = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Address = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] ReadData;
  logic        Hit;
  logic [7:0]  PortIn = 8'h00;
  logic [31:0] PortOut;

  always #5 clk = ~clk;

  io_port_responder #(
    .BASE_ADDR(BASE),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Address(Address),
    .WriteData(WriteData),
    .MemWrite(MemWrite),
    .MemRead(MemRead),
    .ReadData(ReadData),
    .Hit(Hit),
    .PortIn(PortIn),
    .PortOut(PortOut)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: PortIn seen two edges late, a byte queue, a flag.
  logic [31:0] m_out = '0;
  logic [7:0]  m_d1 = '0;
  logic [7:0]  m_d2 = '0;
  logic [7:0]  m_prev = '0;
  bit          m_ovf = 1'b0;
  logic [7:0]  m_q[$];
  bit          m_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit();
    return Address[31:4] == BASE[31:4];
  endfunction

  function automatic logic [31:0] m_status();
    int n;
    n = m_q.size();
    return 32'(n * 8 + (m_ovf ? 4 : 0) + ((n == DEPTH) ? 2 : 0)
               + ((n == 0) ? 1 : 0));
  endfunction

  function automatic logic [31:0] m_read();
    if (!m_hit() || !MemRead) return 32'h0;
    case (Address[3:2])
      2'd0:    return m_out;
      2'd1:    return {24'b0, m_d2};
      2'd2:    return (m_q.size() > 0) ? {24'b0, m_q[0]} : 32'h0;
      default: return m_status();
    endcase
  endfunction

  task automatic cyc();
    bit pop;
    bit push;
    #1;
    if (m_valid) begin
      chk("hit", {31'b0, Hit}, {31'b0, m_hit()});
      chk("readdata", ReadData, m_read());
      chk("portout", PortOut, m_out);
    end
    @(posedge clk);
    #1;
    if (!reset) begin
      m_out = '0;
      m_d1 = '0;
      m_d2 = '0;
      m_prev = '0;
      m_ovf = 1'b0;
      m_q.delete();
      m_valid = 1'b1;
    end else begin
      pop = MemRead && m_hit() && Address[3:2] == 2'd2 && m_q.size() > 0;
      push = (m_d2 != m_prev);
      if (MemWrite && m_hit() && Address[3:2] == 2'd3 && WriteData[2])
        m_ovf = 1'b0;
      if (MemWrite && m_hit() && Address[3:2] == 2'd0)
        m_out = WriteData;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_d2);
        else m_ovf = 1'b1;
      end
      m_prev = m_d2;
      m_d2 = m_d1;
      m_d1 = PortIn;
    end
  endtask

  task automatic idle();
    MemRead = 1'b0;
    MemWrite = 1'b0;
    Address = 32'h0;
    WriteData = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address = a;
    WriteData = d;
    MemWrite = 1'b1;
    cyc();
    idle();
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input logic [31:0] exp);
    Address = a;
    MemRead = 1'b1;
    #1;
    chk(tag, ReadData, exp);
    cyc();
    idle();
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    PortIn = v;
    repeat (n) cyc();
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
    rd("status_reset", A_STAT, 32'h1);

    wr(A_OUT, 32'hDEAD_BEEF);
    chk("portout_store", PortOut, 32'hDEAD_BEEF);
    rd("portout_load", A_OUT, 32'hDEAD_BEEF);
    Address = BASE + 32'h20;
    MemWrite = 1'b1;
    WriteData = 32'h1234_5678;
    #1;
    chk("hit_outside", {31'b0, Hit}, 32'h0);
    cyc();
    idle();
    chk("portout_kept", PortOut, 32'hDEAD_BEEF);

    hold(8'hA5, 3);
    rd("status_one", A_STAT, 32'h8);
    rd("portin_a5", A_IN, 32'hA5);
    rd("pop_a5", A_FIFO, 32'hA5);
    rd("status_empty", A_STAT, 32'h1);

    for (int v = 1; v <= 5; v++) hold(8'(v), 4);
    rd("status_ovf", A_STAT, 32'h26);
    for (int v = 1; v <= 4; v++) rd("pop_order", A_FIFO, 32'(v));
    rd("pop_empty", A_FIFO, 32'h0);
    rd("status_ovf_empty", A_STAT, 32'h5);
    wr(A_STAT, 32'h4);
    rd("status_ovf_clr", A_STAT, 32'h1);

    for (int v = 8'h11; v <= 8'h14; v++) hold(8'(v), 4);
    rd("status_full", A_STAT, 32'h22);
    hold(8'h15, 2);
    rd("pop_push_full", A_FIFO, 32'h11);
    rd("status_full_kept", A_STAT, 32'h22);
    hold(8'h16, 2);
    wr(A_STAT, 32'h4);
    rd("status_set_wins", A_STAT, 32'h26);
    wr(A_STAT, 32'hFFFF_FFFF);
    rd("status_clr", A_STAT, 32'h22);
    for (int v = 8'h12; v <= 8'h15; v++) rd("pop_wrap", A_FIFO, 32'(v));
    rd("status_drained", A_STAT, 32'h1);

    wr(A_OUT, 32'h0000_1234);
    for (int v = 8'h31; v <= 8'h33; v++) hold(8'(v), 4);
    rd("status_three", A_STAT, 32'h18);
    reset = 1'b0;
    PortIn = 8'h00;
    cyc();
    reset = 1'b1;
    rd("status_after_rst", A_STAT, 32'h1);
    chk("portout_after_rst", PortOut, 32'h0);
    repeat (6) cyc();
    rd("status_no_push", A_STAT, 32'h1);

    repeat (1500) begin
      if ($urandom_range(0, 7) == 0) Address = $urandom;
      else Address = BASE + 32'($urandom_range(0, 15));
      MemRead = ($urandom_range(0, 2) == 0);
      MemWrite = ($urandom_range(0, 3) == 0);
      WriteData = $urandom;
      if ($urandom_range(0, 4) == 0) PortIn = 8'($urandom);
      reset = ($urandom_range(0, 299) != 0);
      cyc();
    end
    reset = 1'b1;
    idle();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
